// File: rtl/tft_timing_rx.sv
// Receive side of the TFT timing path: samples an RGB565 stream, recovers
// active-pixel coordinates, measures line/frame timing and tracks lock.
module tft_timing_rx #(
  parameter int unsigned      LOCK_FRAMES = 2,
  parameter int unsigned      CNT_W       = 11,
  parameter logic [CNT_W-1:0] TIMEOUT     = 11'd2047
) (
  input  logic             clk_in,
  input  logic             sys_rst_n,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             de_in,
  input  logic [15:0]      data_in,
  output logic             pix_valid,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic [15:0]      pix_data,
  output logic             frame_start,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             locked,
  output logic             timing_err
);

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  localparam logic [7:0] LOCK_TGT = 8'(LOCK_FRAMES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic             hsync_s1_q, vsync_s1_q, de_s1_q;
  logic             hsync_s2_q, vsync_s2_q, de_s2_q;
  logic [15:0]      data_s1_q;
  logic             pix_valid_q, frame_start_q, frame_pend_q;
  logic [CNT_W-1:0] pix_x_q, pix_y_q;
  logic [15:0]      pix_data_q;
  logic [CNT_W-1:0] h_cnt_q, ha_cnt_q, v_cnt_q, va_cnt_q;
  logic             line_seen_q, line_de_q;
  logic [CNT_W-1:0] h_total_q, h_active_q, v_total_q, v_active_q;
  logic [CNT_W-1:0] h_total_d, h_active_d, v_total_d, v_active_d;
  state_t           state_q, state_d;
  logic [7:0]       match_q, match_d;
  logic [4*CNT_W-1:0] prev_q, prev_d, meas_d;
  logic             hs_rise, vs_rise, de_rise, de_fall, frame_pend;
  logic             meas_ok, lose_lock;

  assign hs_rise    = hsync_s1_q & ~hsync_s2_q;
  assign vs_rise    = vsync_s1_q & ~vsync_s2_q;
  assign de_rise    = de_s1_q & ~de_s2_q;
  assign de_fall    = ~de_s1_q & de_s2_q;
  assign frame_pend = frame_pend_q | vs_rise;

  // A line coincident with the vsync rise closes the old frame's count.
  assign h_total_d  = (hs_rise && line_seen_q) ? h_cnt_q : h_total_q;
  assign h_active_d = de_fall ? ha_cnt_q : h_active_q;
  assign v_total_d  = vs_rise ? (hs_rise ? sat_inc(v_cnt_q) : v_cnt_q) : v_total_q;
  assign v_active_d = vs_rise ? va_cnt_q : v_active_q;
  assign meas_d     = {h_total_d, h_active_d, v_total_d, v_active_d};

  assign meas_ok   = (meas_d == prev_q) && (h_total_d != '0) && (h_active_d != '0)
                     && (v_total_d != '0) && (v_active_d != '0);
  assign lose_lock = (hs_rise && line_seen_q && (h_cnt_q != prev_q[4*CNT_W-1 -: CNT_W]))
                     || (vs_rise && (meas_d != prev_q))
                     || (h_cnt_q == TIMEOUT);

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync_s1_q <= 1'b0; vsync_s1_q <= 1'b0; de_s1_q <= 1'b0; data_s1_q <= '0;
      hsync_s2_q <= 1'b0; vsync_s2_q <= 1'b0; de_s2_q <= 1'b0;
      pix_valid_q <= 1'b0; pix_data_q <= '0; pix_x_q <= '0; pix_y_q <= '0;
      frame_start_q <= 1'b0; frame_pend_q <= 1'b0;
      h_cnt_q <= '0; ha_cnt_q <= '0; v_cnt_q <= '0; va_cnt_q <= '0;
      line_seen_q <= 1'b0; line_de_q <= 1'b0;
      h_total_q <= '0; h_active_q <= '0; v_total_q <= '0; v_active_q <= '0;
    end else begin
      hsync_s1_q <= hsync_in; vsync_s1_q <= vsync_in; de_s1_q <= de_in; data_s1_q <= data_in;
      hsync_s2_q <= hsync_s1_q; vsync_s2_q <= vsync_s1_q; de_s2_q <= de_s1_q;

      pix_valid_q   <= de_s1_q;
      pix_data_q    <= data_s1_q;
      frame_start_q <= de_rise & frame_pend;
      if (de_rise)      pix_x_q <= '0;
      else if (de_s1_q) pix_x_q <= sat_inc(pix_x_q);
      if (de_rise && frame_pend) pix_y_q <= '0;
      else if (de_fall)          pix_y_q <= sat_inc(pix_y_q);
      if (de_rise)      frame_pend_q <= 1'b0;
      else if (vs_rise) frame_pend_q <= 1'b1;

      h_cnt_q <= hs_rise ? CNT_W'(1) : sat_inc(h_cnt_q);
      if (de_s1_q) ha_cnt_q <= de_s2_q ? sat_inc(ha_cnt_q) : CNT_W'(1);
      if (hs_rise) line_seen_q <= 1'b1;
      if (hs_rise)      line_de_q <= 1'b0;
      else if (de_rise) line_de_q <= 1'b1;
      if (vs_rise)      v_cnt_q <= '0;
      else if (hs_rise) v_cnt_q <= sat_inc(v_cnt_q);
      if (vs_rise)                     va_cnt_q <= '0;
      else if (de_rise && !line_de_q)  va_cnt_q <= sat_inc(va_cnt_q);

      h_total_q  <= h_total_d;
      h_active_q <= h_active_d;
      v_total_q  <= v_total_d;
      v_active_q <= v_active_d;
    end
  end

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_SEARCH;
      match_q <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      prev_q  <= prev_d;
    end
  end

  // The reference is cleared on leaving SEARCH so a partial frame never counts.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    prev_d  = prev_q;
    unique case (state_q)
      S_SEARCH: if (vs_rise) begin
        state_d = S_MEASURE;
        match_d = '0;
        prev_d  = '0;
      end
      S_MEASURE: if (vs_rise) begin
        prev_d = meas_d;
        if (meas_ok) begin
          match_d = match_q + 8'd1;
          if (match_q + 8'd1 >= LOCK_TGT) state_d = S_LOCKED;
        end else begin
          match_d = '0;
        end
      end
      S_LOCKED: begin
        if (lose_lock)    state_d = S_SEARCH;
        else if (vs_rise) prev_d  = meas_d;
      end
      default: state_d = S_SEARCH;
    endcase
  end

  always_comb begin
    locked     = (state_q == S_LOCKED);
    timing_err = (state_q == S_LOCKED) && lose_lock;
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_data    = pix_data_q;
  assign frame_start = frame_start_q;
  assign h_total     = h_total_q;
  assign h_active    = h_active_q;
  assign v_total     = v_total_q;
  assign v_active    = v_active_q;

endmodule

// File: tb/tb_tft_timing_rx.sv
// Directed bench for tft_timing_rx using small scaled-down TFT timings.
module tb_tft_timing_rx;

  typedef struct {
    int htot, hs, hb, ha;
    int vtot, vs, vb, va;
  } tim_t;

  logic        clk_in = 1'b0;
  logic        sys_rst_n;
  logic        hsync_in, vsync_in, de_in;
  logic [15:0] data_in;
  logic        pix_valid, frame_start, locked, timing_err;
  logic [10:0] pix_x, pix_y, h_total, h_active, v_total, v_active;
  logic [15:0] pix_data;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_pulses = 0;
  int   e0;
  bit   chk_pix = 0;
  tim_t tim_a, tim_b;

  logic        h1_v = 0, h2_v = 0;
  int          h1_x = 0, h1_y = 0, h2_x = 0, h2_y = 0;
  logic [15:0] h1_d = '0, h2_d = '0;

  always #5 clk_in = ~clk_in;

  tft_timing_rx dut (
    .clk_in(clk_in), .sys_rst_n(sys_rst_n),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in), .data_in(data_in),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .locked(locked), .timing_err(timing_err)
  );

  always @(negedge clk_in) if (timing_err === 1'b1) err_pulses++;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One input cycle; pixel outputs are compared against the stream from two cycles back.
  task automatic step(input logic hs, input logic vs, input logic de,
                      input logic [15:0] d, input int ex, input int ey);
    hsync_in = hs; vsync_in = vs; de_in = de; data_in = d;
    @(negedge clk_in);
    if (chk_pix) begin
      check_val("pix_valid", pix_valid, h2_v);
      check_val("frame_start", frame_start, h2_v && h2_x == 0 && h2_y == 0);
      if (h2_v) begin
        check_val("pix_x", pix_x, h2_x);
        check_val("pix_y", pix_y, h2_y);
        check_val("pix_data", pix_data, h2_d);
      end
    end
    h2_v = h1_v; h2_x = h1_x; h2_y = h1_y; h2_d = h1_d;
    h1_v = de;   h1_x = ex;   h1_y = ey;   h1_d = d;
    @(posedge clk_in); #1;
  endtask

  task automatic drive_frame(input tim_t t, input int stretch_line,
                             input int from_cyc, input int to_cyc);
    int n, len;
    logic de;
    logic [15:0] dat;
    n = 0;
    for (int l = 0; l < t.vtot; l++) begin
      len = t.htot + ((l == stretch_line) ? 1 : 0);
      for (int c = 0; c < len; c++) begin
        if (n >= from_cyc && n < to_cyc) begin
          de  = (l >= t.vs + t.vb) && (l < t.vs + t.vb + t.va)
                && (c >= t.hs + t.hb) && (c < t.hs + t.hb + t.ha);
          dat = {l[7:0], c[7:0]};
          step(c < t.hs, l < t.vs, de, dat, c - (t.hs + t.hb), l - (t.vs + t.vb));
        end
        n++;
      end
    end
  endtask

  task automatic full_frame(input tim_t t);
    drive_frame(t, -1, 0, 1 << 30);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tim_a = '{htot:20, hs:3, hb:4, ha:10, vtot:12, vs:2, vb:2, va:6};
    tim_b = '{htot:15, hs:2, hb:2, ha:8,  vtot:9,  vs:1, vb:2, va:5};
    sys_rst_n = 1'b0;
    hsync_in = 0; vsync_in = 0; de_in = 0; data_in = '0;
    repeat (3) @(negedge clk_in);
    check_val("rst0_pix", {pix_valid, pix_x, pix_y, pix_data, frame_start}, 0);
    check_val("rst0_meas", {h_total, h_active, v_total, v_active}, 0);
    check_val("rst0_lock", {locked, timing_err}, 0);
    sys_rst_n = 1'b1;
    @(posedge clk_in); #1;

    // Timing A: lock after the third vsync rise.
    full_frame(tim_a);
    full_frame(tim_a);
    check_val("a_no_lock_2", locked, 0);
    chk_pix = 1;
    full_frame(tim_a);
    chk_pix = 0;
    check_val("a_locked", locked, 1);
    check_val("a_h_total", h_total, 20);
    check_val("a_h_active", h_active, 10);
    check_val("a_v_total", v_total, 12);
    check_val("a_v_active", v_active, 6);

    // One line stretched by a clock while locked.
    e0 = err_pulses;
    drive_frame(tim_a, 5, 0, 1 << 30);
    check_val("stretch_err", err_pulses - e0, 1);
    check_val("stretch_unlock", locked, 0);
    full_frame(tim_a);
    full_frame(tim_a);
    check_val("relock_early", locked, 0);
    full_frame(tim_a);
    check_val("relock", locked, 1);
    check_val("relock_err", err_pulses - e0, 1);

    // hsync stalls long enough for the h counter to reach the timeout.
    e0 = err_pulses;
    repeat (2100) step(0, 0, 0, 16'h0, 0, 0);
    check_val("timeout_err", err_pulses - e0, 1);
    check_val("timeout_unlock", locked, 0);
    check_val("timeout_h_total", h_total, 20);

    // Timing B.
    full_frame(tim_b);
    full_frame(tim_b);
    chk_pix = 1;
    full_frame(tim_b);
    chk_pix = 0;
    check_val("b_locked", locked, 1);
    check_val("b_h_total", h_total, 15);
    check_val("b_h_active", h_active, 8);
    check_val("b_v_total", v_total, 9);
    check_val("b_v_active", v_active, 5);

    // Reset mid active line.
    drive_frame(tim_b, -1, 0, 3 * 15 + 8);
    check_val("pre_rst_valid", pix_valid, 1);
    sys_rst_n = 1'b0;
    #1;
    check_val("rst_pix", {pix_valid, pix_x, pix_y, pix_data, frame_start}, 0);
    check_val("rst_meas", {h_total, h_active, v_total, v_active}, 0);
    check_val("rst_lock", {locked, timing_err}, 0);
    repeat (3) @(negedge clk_in);
    sys_rst_n = 1'b1;
    @(posedge clk_in); #1;
    drive_frame(tim_b, -1, 3 * 15 + 8, 1 << 30);
    full_frame(tim_b);
    check_val("rst_partial_nolock", locked, 0);
    full_frame(tim_b);
    check_val("rst_one_full_nolock", locked, 0);
    full_frame(tim_b);
    check_val("rst_relock", locked, 1);
    check_val("rst_v_total", v_total, 9);
    check_val("rst_h_total", h_total, 15);

    // Very long active line: coordinate and h_active saturation.
    repeat (2) step(1, 0, 0, 16'h0, 0, 0);
    repeat (2100) step(0, 0, 1, 16'h1234, 0, 0);
    check_val("sat_valid", pix_valid, 1);
    check_val("sat_pix_x", pix_x, 2047);
    repeat (3) step(0, 0, 0, 16'h0, 0, 0);
    check_val("sat_h_active", h_active, 2047);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tft_timing_rx.md
Name: tft_timing_rx

Overview:
- Receive-side counterpart of the TFT timing generator: it samples an incoming parallel RGB565 video stream (hsync, vsync, de, data) and recovers the active-pixel coordinates.
- Measures the line and frame timing, and declares lock once the timing is stable over consecutive frames.
- Sits at the front of a capture/loopback path: it checks the generator output, or ingests an external TFT-style source into the frame buffer writer.

Parameters:
- LOCK_FRAMES, 2, number of consecutive identical frame measurements required to assert locked.
- TIMEOUT, 11'd2047, clk_in cycles without an hsync rising edge before lock is dropped.
- CNT_W, 11, width of all counters and measurement outputs.

Ports:
- clk_in  input  1  pixel clock.
- sys_rst_n  input  1  asynchronous active-low reset.
- hsync_in  input  1  line sync, active high.
- vsync_in  input  1  frame sync, active high.
- de_in  input  1  data enable, high during active pixels.
- data_in  input  16  RGB565 pixel.
- pix_valid  output  1  registered copy of de for the output pixel.
- pix_x  output  11  active-pixel column, 0-based.
- pix_y  output  11  active-line row, 0-based.
- pix_data  output  16  pixel data aligned with pix_valid.
- frame_start  output  1  one-cycle pulse with the first pix_valid of a frame.
- h_total  output  11  measured clocks per line.
- h_active  output  11  measured de-high clocks per line.
- v_total  output  11  measured lines per frame.
- v_active  output  11  measured lines containing de.
- locked  output  1  timing stable.
- timing_err  output  1  one-cycle pulse when lock is lost.

Behaviour:
- Reset (asynchronous, sys_rst_n low): all outputs 0; all counters 0; FSM in SEARCH.
- Input stage: hsync_in, vsync_in, de_in and data_in are registered once (the _d signals). Edges are detected against a second register stage.
- Pixel path latency: 2 clk_in cycles from input pins to pix_* outputs.
- pix_x: 0 on the first de_d cycle of a line, then +1 per de_d cycle.
- pix_y: 0 on the first de line after a vsync rising edge, then +1 at each de falling edge.
- Coordinate counters saturate at 2047.
- frame_start: pulses 1 cycle, coincident with pix_valid where pix_x==0 and pix_y==0.
- h counter: cleared to 1 on each hsync_d rising edge, otherwise +1, saturating at 2047.
  - At each hsync rise after the first line seen, h_total is loaded with the pre-clear count (clocks rise-to-rise).
- h_active: counts de_d-high clocks; latched at each de falling edge.
- v_total: counts hsync rises between vsync rises; latched at each vsync rise.
- v_active: counts lines containing at least one de cycle; latched at each vsync rise.
- Measurements hold their last value until updated. They are not cleared on loss of lock.
- FSM states:
  - SEARCH: locked=0. On a vsync rise, go to MEASURE with match_cnt=0.
  - MEASURE: at each vsync rise, compare {h_total, h_active, v_total, v_active} with the previous frame.
    - Equal and all fields nonzero: match_cnt+1. When match_cnt reaches LOCK_FRAMES-1, go to LOCKED.
    - Otherwise: match_cnt=0.
  - LOCKED: locked=1. Return to SEARCH and pulse timing_err for 1 cycle on any of:
    - a newly latched h_total differs from the locked value;
    - a frame measurement at a vsync rise differs;
    - the h counter reaches TIMEOUT.
- Simultaneous hsync and vsync rise: the line is counted first, then v_total is latched including that line. It becomes line 0 of the new frame.
- Reset mid-frame: the first partial frame is never used for lock. SEARCH requires a full vsync-to-vsync interval.
- pix_* outputs follow the input stream regardless of lock state.

Test Plan:
- Generator timing (H: sync 34, back 46, active 800, total 1090; V: sync 10, back 23, active 480, total 535) -> after 3 vsync rises: h_total=1090, h_active=800, v_total=535, v_active=480, locked=1.
- Same stream -> first pix_valid at pix_x=0, pix_y=0 with frame_start=1, exactly 2 cycles after de_in first rises. Last pixel of the frame: pix_x=799, pix_y=479.
- While locked, one line stretched to 1091 clocks -> timing_err pulses once, locked=0. Lock returns 2 full frames after the timing is restored.
- While locked, hsync_in held low for 2047 cycles -> timing_err pulse, locked=0. h_total keeps 1090.
- 4.3-inch timing (H total 525 / active 480, V total 286 / active 272) -> h_total=525, h_active=480, v_total=286, v_active=272, locked=1.
- Reset asserted mid-line -> all outputs 0 immediately. After release, locked stays 0 for the partial frame and asserts after 2 full matching frames.
